// File: rtl/ring_osc_meter.sv
// ring_osc_meter: multi-channel ring-oscillator enable and gated edge-count frequency meter
module ring_osc_meter #(
  parameter int N_CH       = 4,
  parameter int CH_W       = 2,
  parameter int CNT_W      = 16,
  parameter int GATE_CYC   = 1024,
  parameter int SETTLE_CYC = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_CH-1:0]  osc_in,
  input  logic [CH_W-1:0]  ch_sel,
  input  logic             start,
  input  logic             continuous,
  output logic [N_CH-1:0]  osc_en,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
  output logic             overflow
);
  localparam int SW = $clog2(SETTLE_CYC);
  localparam int GW = $clog2(GATE_CYC + 1);
  typedef enum logic [1:0] {IDLE, SETTLE, GATE, DONE} state_t;
  state_t           state_q, state_d;
  logic [CH_W-1:0]  sel_q, sel_d, sel_clamp;
  logic             mode_q, mode_d;
  logic [2:0]       sync_q, sync_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [GW-1:0]    gate_q, gate_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [N_CH-1:0]  osc_en_q, osc_en_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             count_valid_q, count_valid_d;
  logic             overflow_q, overflow_d;
  logic             pulse;
  // Two synchroniser stages then one history stage; a rising edge is sync[1] high with sync[2] low.
  assign sync_d = {sync_q[1:0], osc_in[sel_q]};
  assign pulse = sync_q[1] & ~sync_q[2];
  assign sel_clamp = {1'b0, ch_sel} > (CH_W+1)'(N_CH - 1) ? CH_W'(N_CH - 1) : ch_sel;
  // Next-state, counters and registered outputs; en low overrides everything back to IDLE.
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    mode_d = mode_q;
    settle_d = settle_q;
    gate_d = gate_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    count_d = count_q;
    overflow_d = overflow_q;
    count_valid_d = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = SETTLE;
        sel_d = sel_clamp;
        mode_d = continuous;
        settle_d = '0;
      end
      SETTLE: begin
        settle_d = settle_q + 1'b1;
        if (settle_q == SW'(SETTLE_CYC - 1)) begin
          state_d = GATE;
          gate_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
        end
      end
      GATE: begin
        gate_d = gate_q + 1'b1;
        cnt_d = pulse && cnt_q != '1 ? cnt_q + 1'b1 : cnt_q;
        ovf_d = ovf_q | (pulse & (cnt_q == '1));
        if (gate_q == GW'(GATE_CYC - 1)) state_d = DONE;
      end
      DONE: begin
        count_d = cnt_q;
        overflow_d = ovf_q;
        count_valid_d = 1'b1;
        state_d = mode_q ? GATE : IDLE;
        gate_d = '0;
        // In continuous mode an edge seen during DONE opens the next window rather than being dropped.
        cnt_d = CNT_W'(pulse);
        ovf_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    if (!en) begin
      state_d = IDLE;
      count_valid_d = 1'b0;
      count_d = count_q;
      overflow_d = overflow_q;
    end
    busy_d = state_d != IDLE;
    osc_en_d = busy_d ? N_CH'(1) << sel_d : '0;
  end
  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q <= '0;
      mode_q <= 1'b0;
      sync_q <= '0;
      settle_q <= '0;
      gate_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      osc_en_q <= '0;
      busy_q <= 1'b0;
      count_q <= '0;
      count_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      mode_q <= mode_d;
      sync_q <= sync_d;
      settle_q <= settle_d;
      gate_q <= gate_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      osc_en_q <= osc_en_d;
      busy_q <= busy_d;
      count_q <= count_d;
      count_valid_q <= count_valid_d;
      overflow_q <= overflow_d;
    end
  end
  assign osc_en = osc_en_q;
  assign busy = busy_q;
  assign count = count_q;
  assign count_valid = count_valid_q;
  assign overflow = overflow_q;
endmodule
